// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - opcode, funct and ALU operation definitions for my_cpu
package cpu_defines;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit integer ALU
module alu
  import cpu_defines::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'd0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, one write port
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is hardwired in the read path so it never depends on storage contents
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/my_cpu.sv
// rtl/my_cpu.sv - single-cycle RV32I integer execution core (OP, OP-IMM, LUI)
module my_cpu
  import cpu_defines::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] inst,
  output logic [31:0] pc,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  alu_op_t     alu_op;
  logic        legal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'd0};

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rs2_data;
    legal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_SUB_SRA) begin
          legal  = (funct3 == F3_ADD) || (funct3 == F3_SR);
          alu_op = (funct3 == F3_ADD) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        // shift amount sits in imm_i[4:0]; the ALU only looks at b[4:0] for shifts
        alu_b = imm_i;
        legal = 1'b1;
        case (funct3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = (funct7 == F7_BASE);
          end
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLTU: alu_op = ALU_SLTU;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SR: begin
            alu_op = (funct7 == F7_SUB_SRA) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == F7_BASE) || (funct7 == F7_SUB_SRA);
          end
          F3_OR:   alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  regfile u_regfile (
    .clk    (cpu_clk),
    .rst    (cpu_rst),
    .we     (legal),
    .waddr  (inst[11:7]),
    .wdata  (alu_y),
    .raddr1 (inst[19:15]),
    .raddr2 (inst[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  alu u_alu (
    .op (alu_op),
    .a  (rs1_data),
    .b  (alu_b),
    .y  (alu_y)
  );

  assign wb_en   = legal;
  assign wb_addr = inst[11:7];
  assign wb_data = alu_y;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) pc <= '0;
    else         pc <= pc + 32'd4;
  end

endmodule

// File: tb/tb_my_cpu.sv
// tb/tb_my_cpu.sv - directed and randomized self-checking bench for my_cpu
module tb_my_cpu;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] inst = 32'd0;
  logic [31:0] pc;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int total = 0;
  int bad = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [31:0] seen;

  my_cpu dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .inst    (inst),
    .pc      (pc),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd);
    return {imm20[19:0], rd[4:0], 7'b0110111};
  endfunction

  // Reference semantics straight from the instruction definitions
  task automatic model_exec(input logic [31:0] i, output logic en, output logic [31:0] d);
    logic [31:0] a, b, imm;
    int f3, f7, sh;
    a   = (i[19:15] == 0) ? 32'd0 : m_regs[i[19:15]];
    b   = (i[24:20] == 0) ? 32'd0 : m_regs[i[24:20]];
    imm = {{20{i[31]}}, i[31:20]};
    f3  = int'(i[14:12]);
    f7  = int'(i[31:25]);
    en  = 1'b0;
    d   = 32'd0;
    if (i[6:0] == 7'b0110111) begin
      en = 1'b1;
      d  = i & 32'hFFFFF000;
    end else if (i[6:0] == 7'b0110011) begin
      sh = int'(b[4:0]);
      if (f7 == 0) begin
        en = 1'b1;
        case (f3)
          0: d = a + b;
          1: d = a << sh;
          2: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3: d = (a < b) ? 32'd1 : 32'd0;
          4: d = a ^ b;
          5: d = a >> sh;
          6: d = a | b;
          default: d = a & b;
        endcase
      end else if (f7 == 32 && f3 == 0) begin
        en = 1'b1;
        d  = a - b;
      end else if (f7 == 32 && f3 == 5) begin
        en = 1'b1;
        d  = $unsigned($signed(a) >>> sh);
      end
    end else if (i[6:0] == 7'b0010011) begin
      sh = int'(i[24:20]);
      en = 1'b1;
      case (f3)
        0: d = a + imm;
        1: begin en = (f7 == 0); d = a << sh; end
        2: d = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        3: d = (a < imm) ? 32'd1 : 32'd0;
        4: d = a ^ imm;
        5: begin
          en = (f7 == 0) || (f7 == 32);
          d  = (f7 == 32) ? $unsigned($signed(a) >>> sh) : a >> sh;
        end
        6: d = a | imm;
        default: d = a & imm;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction, check the combinational outputs, then let the edge happen
  task automatic step(input logic [31:0] i, input logic r, input bit chk_pc, output logic [31:0] obs);
    logic        e_en;
    logic [31:0] e_d;
    @(negedge cpu_clk);
    inst = i;
    cpu_rst = r;
    #1;
    model_exec(i, e_en, e_d);
    obs = wb_data;
    chk("wb_en", {31'd0, wb_en}, {31'd0, e_en});
    if (e_en) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, i[11:7]});
      chk("wb_data", wb_data, e_d);
    end
    if (chk_pc) chk("pc", pc, m_pc);
    @(posedge cpu_clk);
    if (r) begin
      for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
      m_pc = 32'd0;
    end else begin
      if (e_en && i[11:7] != 0) m_regs[i[11:7]] = e_d;
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Read a register through addi x0,rN,0 which has no architectural effect
  task automatic probe(input int rn, input logic [31:0] exp, input string tag);
    logic [31:0] obs;
    step(enc_i(0, rn, 0, 0), 1'b0, 1'b1, obs);
    chk(tag, obs, exp);
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] ri;
    int kind;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    m_pc = 32'd0;

    step(32'd0, 1'b1, 1'b0, obs);
    @(negedge cpu_clk);
    #1;
    chk("reset_pc", pc, 32'd0);
    chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
    for (int k = 1; k < 32; k += 5) probe(k, 32'd0, "reset_reg");

    step(32'h00200093, 1'b0, 1'b1, obs);
    chk("addi_x1_data", obs, 32'd2);
    step(32'h40108133, 1'b0, 1'b1, obs);
    chk("sub_x2_data", obs, 32'd0);
    probe(1, 32'd2, "x1_is_2");
    probe(2, 32'd0, "x2_is_0");

    step(32'hFFF00193, 1'b0, 1'b1, obs);
    probe(3, 32'hFFFFFFFF, "x3_neg1");
    step(enc_r(0, 1, 3, 2, 4), 1'b0, 1'b1, obs);
    probe(4, 32'd1, "slt_x4");
    step(enc_r(0, 1, 3, 3, 5), 1'b0, 1'b1, obs);
    probe(5, 32'd0, "sltu_x5");

    step(enc_u(32'h80000, 6), 1'b0, 1'b1, obs);
    probe(6, 32'h80000000, "lui_x6");
    step(enc_i(32'h404, 6, 5, 7), 1'b0, 1'b1, obs);
    probe(7, 32'hF8000000, "srai_x7");
    step(enc_i(4, 6, 5, 8), 1'b0, 1'b1, obs);
    probe(8, 32'h08000000, "srli_x8");

    step(enc_i(5, 0, 0, 0), 1'b0, 1'b1, obs);
    probe(0, 32'd0, "x0_stays_0");
    probe(1, 32'd2, "x1_untouched");

    step(32'hFFFFFFFF, 1'b0, 1'b1, obs);
    probe(31, 32'd0, "illegal_x31");
    probe(7, 32'hF8000000, "illegal_x7");

    step(enc_i(9, 0, 0, 1), 1'b1, 1'b1, obs);
    @(negedge cpu_clk);
    #1;
    chk("midrst_pc", pc, 32'd0);
    probe(1, 32'd0, "midrst_x1");

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      ri = $urandom;
      case (kind)
        0, 1, 2: ri = enc_r(($urandom_range(0, 3) == 0) ? 32 : 0, $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 31));
        3, 4, 5: ri = enc_i($urandom, $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 31));
        6: ri = enc_u($urandom, $urandom_range(0, 31));
        7: ri = {ri[31:7], 7'b0010011};
        default: ;
      endcase
      step(ri, ($urandom_range(0, 49) == 0), 1'b1, obs);
    end
    for (int k = 0; k < 32; k++) probe(k, m_regs[k], "final_reg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
